// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the per-bank SDRAM test engine.
// The pattern multiplier lives here so the checker and the preload path agree.
package jtsdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WWAIT,
    ST_RREQ,
    ST_RWAIT,
    ST_NEXT,
    ST_END
  } state_t;

  localparam logic [1:0] MODE_RD    = 2'd0;
  localparam logic [1:0] MODE_WR_RD = 2'd1;
  localparam logic [1:0] MODE_ILV   = 2'd2;
  localparam logic [1:0] MODE_RSV   = 2'd3;

  localparam logic [15:0] PAT_MUL = 16'h9E37;

endpackage

// File: rtl/jtsdram_rwbank_if.sv
// Request bus between one bank test engine and the SDRAM controller.
// The engine is the master; the controller answers with ack/rdy/data_read.
interface jtsdram_rwbank_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] din;
  logic [1:0]    din_m;
  logic          ack;
  logic          rdy;
  logic [31:0]   data_read;

  modport master (
    output addr, rd, wr, din, din_m,
    input  ack, rdy, data_read
  );

  modport slave (
    input  addr, rd, wr, din, din_m,
    output ack, rdy, data_read
  );
endinterface

// File: rtl/jtsdram_pattern.sv
// Test pattern for word index i: (i[15:0] * PAT_MUL) ^ seed, sized to DW.
// Shared with the loader so preloaded data and checked data match.
module jtsdram_pattern
  import jtsdram_pkg::*;
#(
  parameter int LENW = 10,
  parameter int DW   = 16
) (
  input  logic [LENW-1:0] idx,
  input  logic [15:0]     seed,
  output logic [DW-1:0]   val
);

  logic [15:0] i16;
  logic [15:0] mix;

  generate
    if (LENW >= 16) begin : g_wide
      assign i16 = idx[15:0];
    end else begin : g_narrow
      assign i16 = {{(16-LENW){1'b0}}, idx};
    end
  endgenerate

  assign mix = (i16 * PAT_MUL) ^ seed;

  generate
    if (DW <= 16) begin : g_trunc
      assign val = mix[DW-1:0];
    end else begin : g_ext
      assign val = {{(DW-16){1'b0}}, mix};
    end
  endgenerate

endmodule

// File: rtl/jtsdram_rwbank.sv
// Single-bank SDRAM test engine: writes and/or reads back a seeded
// pattern over 2**LENW words, counting mismatches and ack timeouts.
module jtsdram_rwbank
  import jtsdram_pkg::*;
#(
  parameter int          AW   = 22,
  parameter int          DW   = 16,
  parameter int          LENW = 10,
  parameter int unsigned BASE = 0,
  parameter int          ECW  = 8,
  parameter int          TOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [15:0]    seed,
  jtsdram_rwbank_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           bad,
  output logic [ECW-1:0] err_cnt,
  output logic [AW-1:0]  fail_addr,
  output logic           timeout
);

  localparam int TW = $clog2(TOUT + 1);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  state_t          state;
  logic [1:0]      mode_q;
  logic [15:0]     seed_q;
  logic [LENW-1:0] idx;
  logic            wphase;
  logic [TW-1:0]   tcnt;
  logic            early;
  logic [DW-1:0]   early_data;
  logic [DW-1:0]   pat;
  logic [DW-1:0]   rdata;
  logic            got;
  logic            last;
  logic            tmo;

  jtsdram_pattern #(
    .LENW (LENW),
    .DW   (DW)
  ) u_pat (
    .idx  (idx),
    .seed (seed_q),
    .val  (pat)
  );

  // ack+rdy in one cycle leaves a pending completion for the wait state
  assign got   = early | bus.rdy;
  assign rdata = early ? early_data : bus.data_read[DW-1:0];
  assign last  = &idx;
  assign tmo   = (tcnt == TW'(TOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bus.addr   <= BASE_A;
      bus.rd     <= 1'b0;
      bus.wr     <= 1'b0;
      bus.din    <= '0;
      bus.din_m  <= 2'b11;
      busy       <= 1'b0;
      done       <= 1'b0;
      bad        <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      mode_q     <= MODE_RD;
      seed_q     <= '0;
      idx        <= '0;
      wphase     <= 1'b0;
      tcnt       <= '0;
      early      <= 1'b0;
      early_data <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= (mode == MODE_RSV) ? MODE_RD : mode;
            seed_q    <= seed;
            bad       <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            idx       <= '0;
            wphase    <= (mode == MODE_WR_RD);
            state     <= (mode == MODE_WR_RD || mode == MODE_ILV)
                         ? ST_WREQ : ST_RREQ;
          end
        end
        ST_WREQ: begin
          if (!bus.wr) begin
            bus.wr    <= 1'b1;
            bus.addr  <= BASE_A + AW'(idx);
            bus.din   <= pat;
            bus.din_m <= 2'b00;
            tcnt      <= '0;
          end else if (bus.ack) begin
            bus.wr    <= 1'b0;
            bus.din_m <= 2'b11;
            early     <= bus.rdy;
            state     <= ST_WWAIT;
          end else if (tmo) begin
            bus.wr    <= 1'b0;
            bus.din_m <= 2'b11;
            timeout   <= 1'b1;
            bad       <= 1'b1;
            state     <= ST_END;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_WWAIT: begin
          if (got) begin
            early <= 1'b0;
            state <= (mode_q == MODE_ILV) ? ST_RREQ : ST_NEXT;
          end
        end
        ST_RREQ: begin
          if (!bus.rd) begin
            bus.rd   <= 1'b1;
            bus.addr <= BASE_A + AW'(idx);
            tcnt     <= '0;
          end else if (bus.ack) begin
            bus.rd     <= 1'b0;
            early      <= bus.rdy;
            early_data <= bus.data_read[DW-1:0];
            state      <= ST_RWAIT;
          end else if (tmo) begin
            bus.rd  <= 1'b0;
            timeout <= 1'b1;
            bad     <= 1'b1;
            state   <= ST_END;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_RWAIT: begin
          if (got) begin
            early <= 1'b0;
            if (rdata != pat) begin
              bad <= 1'b1;
              if (!(&err_cnt)) err_cnt <= err_cnt + ECW'(1);
              if (!bad) fail_addr <= bus.addr;
            end
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last) begin
            if (wphase) begin
              wphase <= 1'b0;
              idx    <= '0;
              state  <= ST_RREQ;
            end else begin
              state <= ST_END;
            end
          end else begin
            idx   <= idx + LENW'(1);
            state <= (mode_q == MODE_ILV || wphase) ? ST_WREQ : ST_RREQ;
          end
        end
        ST_END: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtsdram_rwbank.sv
// Bench for the bank test engine: randomised controller model with an
// array memory and a queue-based reference of the expected request stream.
module tb_jtsdram_rwbank;

  localparam int AW   = 22;
  localparam int DW   = 16;
  localparam int LENW = 3;
  localparam int ECW  = 2;
  localparam int TOUT = 255;
  localparam int unsigned BASE = 32'h3FFFFC;
  localparam int NW = 1 << LENW;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     mode;
  logic [15:0]    seed;
  logic           busy, done, bad, timeout;
  logic [ECW-1:0] err_cnt;
  logic [AW-1:0]  fail_addr;

  jtsdram_rwbank_if #(.AW(AW), .DW(DW)) bus ();

  jtsdram_rwbank #(
    .AW(AW), .DW(DW), .LENW(LENW), .BASE(BASE), .ECW(ECW), .TOUT(TOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .bad       (bad),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem [NW];
  logic        log_wr [$];
  logic [21:0] log_addr [$];
  bit          hold_ack = 0;
  bit          slow_rdy = 0;
  bit          stuck    = 0;
  int          both_hi  = 0;
  int          rd_hi    = 0;

  bit          owed = 0;
  bit          owed_rd;
  logic [2:0]  owed_idx;
  int          wait_cnt = 0;
  int          rdy_cnt  = 0;

  function automatic logic [15:0] ref_pat(input int i, input logic [15:0] s);
    int unsigned p;
    p = i * 32'h9E37;
    return p[15:0] ^ s;
  endfunction

  function automatic logic [21:0] word_addr(input int i);
    return 22'(BASE + i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic deliver();
    logic [15:0] junk;
    junk     = 16'($urandom);
    bus.rdy  = 1'b1;
    if (owed_rd) bus.data_read = {junk, mem[owed_idx] | {15'b0, stuck}};
    else         bus.data_read = {junk, 16'($urandom)};
    owed     = 0;
    wait_cnt = $urandom_range(0, 2);
  endtask

  // Controller model: random ack delay, random ack-to-rdy delay (0 = same cycle)
  always @(negedge clk) begin
    bus.ack = 1'b0;
    bus.rdy = 1'b0;
    if (bus.rd && bus.wr) both_hi++;
    if (bus.rd) rd_hi++;
    if (rst) begin
      owed     = 0;
      wait_cnt = 0;
    end else if (owed) begin
      rdy_cnt--;
      if (rdy_cnt <= 0) deliver();
    end else if ((bus.rd || bus.wr) && !hold_ack) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        bus.ack = 1'b1;
        log_wr.push_back(bus.wr);
        log_addr.push_back(bus.addr);
        if (bus.wr) mem[bus.addr[2:0]] = bus.din;
        owed_rd  = bus.rd;
        owed_idx = bus.addr[2:0];
        rdy_cnt  = slow_rdy ? 20 : $urandom_range(0, 2);
        if (rdy_cnt == 0) deliver();
        else owed = 1;
      end
    end
  end

  task automatic preload(input logic [15:0] s, input int bad_word,
                         input logic [15:0] bad_val, input bit all_bad);
    for (int i = 0; i < NW; i++) begin
      logic [21:0] a;
      a = word_addr(i);
      mem[a[2:0]] = ref_pat(i, s);
      if (all_bad) mem[a[2:0]] = ref_pat(i, s) ^ 16'h8000;
      if (i == bad_word) mem[a[2:0]] = bad_val;
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_addr"}, bus.addr, BASE);
    chk({pfx, "_rd"}, bus.rd, 0);
    chk({pfx, "_wr"}, bus.wr, 0);
    chk({pfx, "_din"}, bus.din, 0);
    chk({pfx, "_din_m"}, bus.din_m, 3);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_bad"}, bad, 0);
    chk({pfx, "_timeout"}, timeout, 0);
    chk({pfx, "_err_cnt"}, err_cnt, 0);
    chk({pfx, "_fail_addr"}, fail_addr, 0);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [15:0] s);
    @(negedge clk);
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic run_mode(input string tag, input logic [1:0] m,
                          input logic [15:0] s, input bit dbl_start);
    logic [15:0] pre [NW];
    logic        e_wr [$];
    logic [21:0] e_addr [$];
    int          errs, md, seq_bad;
    logic [21:0] ffa;
    pre = mem;
    log_wr.delete();
    log_addr.delete();
    both_hi = 0;
    md   = (m == 2'd3) ? 0 : int'(m);
    errs = 0;
    ffa  = '0;
    for (int i = 0; i < NW; i++) begin
      logic [15:0] got;
      logic [21:0] a;
      a = word_addr(i);
      if (md == 2) begin
        e_wr.push_back(1'b1);
        e_addr.push_back(a);
      end
      e_wr.push_back(1'b0);
      e_addr.push_back(a);
      got = (md == 0) ? pre[a[2:0]] : ref_pat(i, s);
      got = got | {15'b0, stuck};
      if (got != ref_pat(i, s)) begin
        if (errs == 0) ffa = a;
        errs++;
      end
    end
    if (md == 1)
      for (int i = NW - 1; i >= 0; i--) begin
        e_wr.push_front(1'b1);
        e_addr.push_front(word_addr(i));
      end
    pulse_start(m, s);
    if (dbl_start) begin
      repeat (4) @(negedge clk);
      chk({tag, "_busy"}, busy, 1);
      pulse_start(2'd2, ~s);
    end
    wait_done(tag);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_bad"}, bad, (errs != 0));
    chk({tag, "_err_cnt"}, err_cnt, (errs > 3) ? 3 : errs);
    chk({tag, "_fail_addr"}, fail_addr, ffa);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_rdwr_overlap"}, both_hi, 0);
    chk({tag, "_seq_len"}, log_wr.size(), e_wr.size());
    seq_bad = 0;
    for (int k = 0; k < e_wr.size() && k < log_wr.size(); k++)
      if (log_wr[k] !== e_wr[k] || log_addr[k] !== e_addr[k]) seq_bad++;
    chk({tag, "_seq"}, seq_bad, 0);
  endtask

  initial begin
    logic [15:0] s;
    int c;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    seed  = 16'h0;
    bus.ack       = 1'b0;
    bus.rdy       = 1'b0;
    bus.data_read = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    preload(16'h0000, -1, 16'h0, 0);
    run_mode("m0_clean", 2'd0, 16'h0000, 0);

    preload(16'h0000, 5, 16'hDEAD, 0);
    run_mode("m0_word5", 2'd0, 16'h0000, 0);

    for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
    run_mode("m1_wrap", 2'd1, 16'h1234, 1);

    stuck = 1;
    s = 16'($urandom);
    for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
    run_mode("m2_stuck", 2'd2, s, 0);
    stuck = 0;

    s = 16'($urandom);
    preload(s, $urandom_range(0, NW - 1), 16'($urandom), 0);
    run_mode("m3_as_m0", 2'd3, s, 0);

    s = 16'($urandom);
    preload(s, -1, 16'h0, 1);
    run_mode("sat", 2'd0, s, 0);

    hold_ack = 1;
    rd_hi    = 0;
    pulse_start(2'd0, 16'h0);
    wait_done("tout");
    chk("tout_timeout", timeout, 1);
    chk("tout_bad", bad, 1);
    chk("tout_rd_cycles", rd_hi, TOUT);
    chk("tout_rd_low", bus.rd, 0);
    chk("tout_err_cnt", err_cnt, 0);
    hold_ack = 0;

    slow_rdy = 1;
    log_wr.delete();
    log_addr.delete();
    preload(16'h0000, -1, 16'h0, 0);
    pulse_start(2'd0, 16'h0);
    c = 0;
    while (log_wr.size() == 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #2;
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    slow_rdy = 0;
    s = 16'($urandom);
    preload(s, -1, 16'h0, 0);
    run_mode("rerun", 2'd0, s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtsdram_rwbank.md
Name: jtsdram_rwbank

Overview:
- Parametrised single-bank SDRAM test engine: the next generation of the per-bank read checker.
- Adds bank writes, three test modes, a configurable test span, a saturating error counter, a first-fail address capture and an ack timeout.
- One instance per SDRAM bank sits under the checker top, driving the baN_* request interface of the SDRAM controller.
- The top's sequencer starts it and collects done/bad.

Parameters:
- AW, 22, SDRAM word address width.
- DW, 16, compared data width (≤32, LSBs of data_read).
- LENW, 10, log2 of words tested per run (span = 2**LENW).
- BASE, 0, first word address of the span.
- ECW, 8, error counter width (saturating).
- TOUT, 255, max cycles from request to ack before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; starts a run when idle
- mode  in  2  0 read-only check, 1 write-all then read-all, 2 interleaved write/read-back per word, 3 reserved (treated as 0)
- seed  in  16  pattern seed, sampled on start
- addr  out  AW  request word address
- rd  out  1  read request
- wr  out  1  write request
- din  out  DW  write data
- din_m  out  2  write byte mask, 0 = byte written
- ack  in  1  controller accepted request
- rdy  in  1  read data valid / write complete
- data_read  in  32  controller read data
- busy  out  1  run in progress
- done  out  1  high from end of run until next start
- bad  out  1  sticky: any mismatch or timeout since start
- err_cnt  out  ECW  mismatch count, saturates at all-ones
- fail_addr  out  AW  address of first mismatch
- timeout  out  1  sticky: ack not received within TOUT

Behaviour:
- Reset values:
  - addr = BASE, rd = wr = 0, din = 0, din_m = 2'b11.
  - busy = done = bad = timeout = 0, err_cnt = 0, fail_addr = 0.
  - State IDLE.
- Pattern: ref(i) = (i[15:0] * 16'h9E37) ^ seed_q, truncated/zero-extended to DW; i = word index 0..2**LENW-1, addr = BASE + i (mod 2**AW).
- States: IDLE, WREQ, WWAIT, RREQ, RWAIT, NEXT, END.
- IDLE:
  - On start: latch seed/mode, clear bad/err_cnt/fail_addr/timeout/done, set i = 0, busy = 1.
  - Then go to WREQ for modes 1 and 2, RREQ for modes 0 and 3.
  - start while busy is ignored.
- WREQ:
  - Drive wr = 1, din = ref(i), din_m = 2'b00.
  - Hold until ack, then drop wr the following cycle and go to WWAIT.
- WWAIT: wait for rdy.
  - Mode 2: go to RREQ for the same i.
  - Mode 1: go to NEXT.
- RREQ: drive rd = 1 until ack, then drop and go to RWAIT.
- RWAIT:
  - On rdy, compare data_read[DW-1:0] with ref(i).
  - On mismatch: bad = 1, err_cnt++ (saturating), and fail_addr = addr if this is the first mismatch.
  - Then go to NEXT.
- NEXT:
  - If i is last and the current phase is the write phase of mode 1: restart i = 0 in RREQ.
  - If i is last otherwise: go to END.
  - Else i++, return to the current phase's request state.
- END: busy = 0, done = 1, go to IDLE. done stays high in IDLE until the next start.
- Request/ack:
  - rd and wr are never high together.
  - Request is held stable (addr/din) until ack.
  - ack and rdy in the same cycle are both honoured: treat as ack then immediate rdy, giving one extra cycle.
- Timeout:
  - A counter runs while rd or wr is asserted without ack.
  - On reaching TOUT: timeout = bad = 1, drop the request, go to END.
- rdy seen outside WWAIT/RWAIT is ignored.
- Reset mid-run returns all outputs to reset values asynchronously.
- Latency per word, with an ack-to-rdy delay of N cycles: mode 0 is 3+N cycles minimum.

Decomposition:
- Shared package jtsdram_pkg:
  - State encoding.
  - Mode constants (MODE_RD, MODE_WR_RD, MODE_ILV).
  - Pattern multiplier 16'h9E37.
- One natural sub-module, jtsdram_pattern: combinational ref(i, seed), reused by the programming loader so preload and check agree.

Test Plan:
- Mode 0, LENW=4, BASE=0, seed=0, model memory preloaded with ref(i) → 16 reads at addr 0..15, done=1, bad=0, err_cnt=0, wr never high.
- Mode 0, same preload but word 5 corrupted to 16'hDEAD → bad=1, err_cnt=1, fail_addr=5, run completes all 16 reads.
- Mode 1, LENW=3, seed=16'h1234, BASE=22'h3FFFFC → 8 writes then 8 reads at 3FFFFC..3FFFFF,000000..000003 (wrap), bad=0.
- Mode 2, LENW=2, model stuck-at data bit 0 → sequence W0 R0 W1 R1 ...; mismatch only where ref bit0=0, err_cnt matches count.
- Model withholds ack for 300 cycles with TOUT=255 → timeout=1, bad=1, rd drops at cycle 255, done=1.
- ECW=2, 8 corrupted words → err_cnt saturates at 3. Assert rst mid-run during RWAIT → all outputs return to reset values immediately, then start re-runs cleanly.
